sm83_int_ctrl: RTL and testbench
================================

Name: sm83_int_ctrl

Overview:
- Interrupt controller at the far end of the SM83 core's interrupt dispatch interface.
- Edge-detects five peripheral request lines into the IF register (0xFF0F) and masks them with the core's IE register.
- Presents one prioritised request and vector to the core, and clears the serviced IF bit when the core acknowledges.
- Sits beside the core on the I/O bus. The core owns IE and IME; this block owns IF and the dispatch handshake.

Parameters:
- N_SRC, 5, number of interrupt sources (bit 0 = VBlank, highest priority; bit 4 = Joypad, lowest).
- VEC_BASE, 16'h0040, vector of source 0.
- VEC_STRIDE, 8, vector spacing in bytes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- irq_src  in  N_SRC  level request lines from peripherals; a 0->1 transition raises a request.
- ie  in  9  core IE register (r8_t); bits [N_SRC-1:0] used, the rest ignored.
- bus_cs  in  1  IF register selected this cycle (address decode is external).
- bus_we  in  1  write strobe, qualified by bus_cs.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  read data, combinational: {3'b111, if_q}.
- int_req  out  1  registered; a dispatch is pending.
- int_vec  out  16  registered; vector for the pending dispatch, stable while int_req=1.
- int_ack  in  1  one-cycle pulse from the core, accepting the current int_vec.
- wake  out  1  combinational: |(if_q & ie[N_SRC-1:0]); exits HALT regardless of IME or FSM state.

Behaviour:
- Reset values: if_q=0, src_d=0, int_req=0, int_vec=16'h0000, FSM=IDLE, latched index=0. With if_q=0, bus_rdata=8'hE0 and wake=0.
- Edge detect: src_d <= irq_src every cycle; rise = irq_src & ~src_d. A level held high raises only one request.
- IF next-value precedence, per bit:
  - bus write (bus_cs & bus_we) loads wdata[N_SRC-1:0];
  - otherwise, ack clear of the latched bit applies;
  - rise is then OR'd in, so a rise always wins over a write-0 or an ack clear in the same cycle.
- pending = if_q & ie[N_SRC-1:0]; sel = lowest set index of pending.
- FSM IDLE:
  - if pending != 0: latch sel, int_vec <= VEC_BASE + VEC_STRIDE*sel, int_req <= 1, go REQ;
  - else stay.
- FSM REQ:
  - int_req=1 and int_vec held constant, even if a higher-priority source arrives.
  - int_ack: clear if_q[latched], int_req <= 0, go GAP.
  - Latched bit no longer pending (bus write cleared it, or ie masked it) and no ack: withdraw, int_req <= 0, go GAP.
  - Ack and withdrawal in the same cycle: ack wins.
- FSM GAP: one cycle with int_req=0, then IDLE. Gives the core a guaranteed deassertion between dispatches. Re-arbitration happens in IDLE.
- int_ack outside REQ is ignored; if_q is unchanged.
- Minimum latency:
  - rise in cycle N -> if_q set at edge N+1 -> int_req=1 after edge N+2;
  - back-to-back dispatches are separated by at least one GAP cycle plus one IDLE cycle.
- Reset mid-handshake: all state returns to reset values in the next cycle; a pending ack is discarded.
- Out of scope: IME gating (core side) and the DMG "IE push" vector-0 quirk.

Decomposition:
- Into sm83_pkg:
  - int_src_t enum (INT_VBLANK, INT_STAT, INT_TIMER, INT_SERIAL, INT_JOYPAD);
  - localparams ADDR_IF=16'hFF0F and ADDR_IE=16'hFFFF;
  - int_ctrl_state_t enum (IDLE, REQ, GAP).
- One sub-module: sm83_prio_enc, a combinational lowest-set-bit encoder (N_SRC in; index plus valid out).

Test Plan:
- Reset, then ie=9'h01, irq_src=5'b00001 at cycle 0 -> if_q=5'h01 after edge 1; int_req=1, int_vec=16'h0040 after edge 2; bus read returns 8'hE1.
- ie=9'h1F, rise on bits 2 and 4 together -> int_vec=16'h0050. Ack -> if_q=5'h10, GAP cycle, then int_vec=16'h0060. Second ack -> if_q=0, int_req stays 0.
- In REQ for bit 2, raise bit 0 -> int_vec stays 16'h0050 until ack; next dispatch is 16'h0040.
- In REQ for bit 3, bus write 8'h00 with no ack -> int_req falls next cycle, if_q=0, no ack-clear side effects.
- Hold irq_src[1]=1 for 20 cycles with ie=9'h02 -> exactly one dispatch (16'h0048). After its ack, if_q[1] remains 0.
- Rise on bit 1 in the same cycle as an ack of latched bit 1 -> if_q[1]=1 afterwards, and a new dispatch to 16'h0048 follows the GAP. Separately, assert rst during REQ -> int_req=0, int_vec=16'h0000, bus_rdata=8'hE0 next cycle.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and addresses for the SM83 interrupt controller slice.
package sm83_pkg;

  typedef enum logic [2:0] {
    INT_VBLANK = 3'd0,
    INT_STAT   = 3'd1,
    INT_TIMER  = 3'd2,
    INT_SERIAL = 3'd3,
    INT_JOYPAD = 3'd4
  } int_src_t;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } int_ctrl_state_t;

endpackage

// File: rtl/sm83_prio_enc.sv
// Combinational lowest-set-bit encoder; bit 0 has the highest priority.
module sm83_prio_enc #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/sm83_int_ctrl.sv
// SM83 interrupt controller: edge-detected IF register, IE masking and a
// registered request/ack dispatch handshake towards the core.
module sm83_int_ctrl
  import sm83_pkg::*;
#(
  parameter int          N_SRC      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [8:0]       ie,
  input  logic             bus_cs,
  input  logic             bus_we,
  input  logic [7:0]       bus_wdata,
  output logic [7:0]       bus_rdata,
  output logic             int_req,
  output logic [15:0]      int_vec,
  input  logic             int_ack,
  output logic             wake
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] if_q, if_d;
  logic [N_SRC-1:0] src_d_q;
  logic [N_SRC-1:0] rise, pending, ack_clr;
  logic [IW-1:0]    idx_q, sel_idx;
  logic             sel_valid;
  logic             int_req_q;
  logic [15:0]      int_vec_q;
  int_ctrl_state_t  state_q;
  logic             unused_bits;

  assign unused_bits = ^{ie[8:N_SRC], bus_wdata[7:N_SRC]};

  assign rise    = irq_src & ~src_d_q;
  assign pending = if_q & ie[N_SRC-1:0];
  assign ack_clr = (state_q == REQ && int_ack) ? (N_SRC'(1) << idx_q) : '0;

  // A write replaces IF outright; a same-cycle rise still gets OR'd on top.
  always_comb begin
    if_d = (bus_cs && bus_we) ? bus_wdata[N_SRC-1:0] : (if_q & ~ack_clr);
    if_d = if_d | rise;
  end

  sm83_prio_enc #(.N(N_SRC), .IW(IW)) u_prio (
    .req_i   (pending),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_q    <= '0;
      src_d_q <= '0;
    end else begin
      if_q    <= if_d;
      src_d_q <= irq_src;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      int_req_q <= 1'b0;
      int_vec_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            idx_q     <= sel_idx;
            int_vec_q <= VEC_BASE + 16'(VEC_STRIDE) * 16'(sel_idx);
            int_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // Ack takes precedence; otherwise withdraw once the latched bit drops.
          if (int_ack || !pending[idx_q]) begin
            int_req_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: state_q <= IDLE;
        default: begin
          int_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign int_req   = int_req_q;
  assign int_vec   = int_vec_q;
  assign bus_rdata = {{(8 - N_SRC){1'b1}}, if_q};
  assign wake      = |pending;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Directed bench for sm83_int_ctrl; dispatch vectors are checked through a
// scoreboard queue filled as stimulus is applied.
module tb_sm83_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_src;
  logic [8:0]  ie;
  logic        bus_cs, bus_we;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        int_req;
  logic [15:0] int_vec;
  logic        int_ack;
  logic        wake;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  sm83_int_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .ie        (ie),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .wake      (wake)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  // Every new int_req assertion must match the next queued vector.
  always @(negedge clk) begin
    if (int_req && !req_prev) begin
      if (exp_q.size() == 0)
        chk("dispatch_unexpected", 32'(exp_q.size()), 32'd1);
      else
        chk("dispatch_vec", {16'h0, int_vec}, {16'h0, exp_q.pop_front()});
    end
    req_prev = int_req;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; irq_src = '0; ie = '0; bus_cs = 0; bus_we = 0;
    bus_wdata = '0; int_ack = 0;
    step(2);
    rst = 1'b0;
    step();
    chk("rst_req", {31'h0, int_req}, 32'd0);
    chk("rst_vec", {16'h0, int_vec}, 32'h0000);
    chk("rst_rdata", {24'h0, bus_rdata}, 32'hE0);
    chk("rst_wake", {31'h0, wake}, 32'd0);

    // Single VBlank: IF after one edge, request after two.
    ie = 9'h01; irq_src = 5'b00001; exp_q.push_back(16'h0040);
    step();
    chk("t1_if", {24'h0, bus_rdata}, 32'hE1);
    chk("t1_req_early", {31'h0, int_req}, 32'd0);
    chk("t1_wake", {31'h0, wake}, 32'd1);
    step();
    chk("t1_req", {31'h0, int_req}, 32'd1);
    chk("t1_vec", {16'h0, int_vec}, 32'h0040);
    ack_pulse();
    chk("t1_if_clr", {24'h0, bus_rdata}, 32'hE0);
    irq_src = '0;
    step(2);

    // Timer and Joypad together: Timer first, Joypad after the GAP.
    ie = 9'h1F; irq_src = 5'b10100;
    exp_q.push_back(16'h0050); exp_q.push_back(16'h0060);
    step(2);
    chk("t2_vec0", {16'h0, int_vec}, 32'h0050);
    ack_pulse();
    chk("t2_if_after_ack", {24'h0, bus_rdata}, 32'hF0);
    chk("t2_gap", {31'h0, int_req}, 32'd0);
    step();
    chk("t2_idle", {31'h0, int_req}, 32'd0);
    step();
    chk("t2_vec1", {16'h0, int_vec}, 32'h0060);
    ack_pulse();
    chk("t2_if_empty", {24'h0, bus_rdata}, 32'hE0);
    step(3);
    chk("t2_req_stays0", {31'h0, int_req}, 32'd0);
    irq_src = '0;
    step();

    // Higher priority arrival while in REQ does not disturb int_vec.
    irq_src = 5'b00100;
    exp_q.push_back(16'h0050); exp_q.push_back(16'h0040);
    step(2);
    irq_src = 5'b00101;
    step();
    chk("t3_hold_vec", {16'h0, int_vec}, 32'h0050);
    step();
    chk("t3_hold_req", {31'h0, int_req}, 32'd1);
    chk("t3_hold_vec2", {16'h0, int_vec}, 32'h0050);
    ack_pulse();
    step(2);
    chk("t3_next_vec", {16'h0, int_vec}, 32'h0040);
    ack_pulse();
    irq_src = '0;
    step(2);

    // Bus write clears the latched Serial bit: request is withdrawn.
    irq_src = 5'b01000; exp_q.push_back(16'h0058);
    step(2);
    chk("t4_vec", {16'h0, int_vec}, 32'h0058);
    bus_cs = 1; bus_we = 1; bus_wdata = 8'h00;
    step();
    bus_cs = 0; bus_we = 0;
    chk("t4_if_written", {24'h0, bus_rdata}, 32'hE0);
    step();
    chk("t4_withdrawn", {31'h0, int_req}, 32'd0);
    step(2);
    chk("t4_stay_idle", {31'h0, int_req}, 32'd0);
    irq_src = '0;
    step();

    // Held level raises exactly one request.
    ie = 9'h02; irq_src = 5'b00010; exp_q.push_back(16'h0048);
    step(2);
    ack_pulse();
    step(17);
    chk("t5_if1_clear", {24'h0, bus_rdata}, 32'hE0);
    chk("t5_no_redispatch", {31'h0, int_req}, 32'd0);
    irq_src = '0;
    step();

    // Rise coincides with the ack of the same bit: rise wins.
    irq_src = 5'b00010;
    exp_q.push_back(16'h0048); exp_q.push_back(16'h0048);
    step(2);
    irq_src = '0;
    step();
    irq_src = 5'b00010; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t6_if_kept", {24'h0, bus_rdata}, 32'hE2);
    chk("t6_gap", {31'h0, int_req}, 32'd0);
    step(2);
    chk("t6_redispatch", {31'h0, int_req}, 32'd1);

    // Reset in the middle of REQ with an ack pending.
    rst = 1'b1; irq_src = '0; int_ack = 1'b1;
    step();
    rst = 1'b0; int_ack = 1'b0;
    chk("t7_req", {31'h0, int_req}, 32'd0);
    chk("t7_vec", {16'h0, int_vec}, 32'h0000);
    chk("t7_rdata", {24'h0, bus_rdata}, 32'hE0);
    step(3);
    chk("t7_quiet", {31'h0, int_req}, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
